// File: rtl/mem_resp.sv
// mem_resp: wait-stated single-port word memory answering CPU MAR/MDR requests.
// Define MEM_RESP_PARITY_EN to add a stored even-parity bit per word and the perr check.
module mem_resp #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              mdr_ld,
  output logic              busy,
  output logic              perr
);

  localparam int DEPTH = 1 << ADDR_W;
  // WAIT is left when the counter reads zero, so it is loaded with one less than the wait count.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d = ACK;
        if (we_q) mem_wr  = 1'b1;
        else      rdata_d = mem[addr_q];
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset: contents survive reset, and a reset-cleared state cannot write.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[addr_q] <= wdata_q;
  end

  assign rdata  = rdata_q;
  assign ack    = (state_q == ACK);
  assign mdr_ld = ack & ~we_q;
  assign busy   = (state_q != IDLE);

`ifdef MEM_RESP_PARITY_EN
  logic              par_mem [DEPTH];
  logic              perr_q, perr_d;
  // Debug hook: idle by default, overridden from a bench to plant a bad stored parity bit.
  logic              dbg_par_force;
  logic [ADDR_W-1:0] dbg_par_addr;
  logic              dbg_par_val;

  always_comb begin
    dbg_par_force = 1'b0;
    dbg_par_addr  = '0;
    dbg_par_val   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_wr)             par_mem[addr_q]       <= ^wdata_q;
    else if (dbg_par_force) par_mem[dbg_par_addr] <= dbg_par_val;
  end

  always_comb begin
    perr_d = perr_q;
    if (state_q == ACCESS) perr_d = ~we_q & ((^mem[addr_q]) ^ par_mem[addr_q]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign perr = perr_q & mdr_ld;
`else
  assign perr = 1'b0;
`endif

endmodule
